vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM (1-cycle read latency, byte-enable writes) between the VGA scan-out engine and the CPU data bus.
- The VGA engine presents a word address and expects a stable 32-bit word. The arbiter fetches that word only when the address changes and holds it in a local register.
- CPU loads/stores use a req/ack handshake and are stalled only while a VGA fetch is in flight.
- Sits between the display controller, the CPU memory-mapped video region and the VRAM macro.

Parameters:
- AW, 9, word-address width of VRAM and both requester address ports
- VRAM_WORDS, 300, number of populated words (40x30 chars / 4 bytes per word); addresses >= VRAM_WORDS are out of range

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- vga_addr  in  AW  word address requested by scan-out; changes at most once per 8 cycles
- vga_data  out  32  last fetched word for the current vga_addr
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_be  in  4  byte enables for store (bit i -> byte i)
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- mem_en  out  1  VRAM access enable (combinational, IDLE only)
- mem_we  out  4  VRAM byte write enables
- mem_addr  out  AW  VRAM address
- mem_wdata  out  32  VRAM write data
- mem_rdata  in  32  VRAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values:
  - state=IDLE, vga_data=0, vga_tag=0, tag_valid=0, last_vga=0, cpu_ack=0, cpu_rdata=0.
  - mem_en=0 and mem_we=0 while reset is high.
- vga_pending = !tag_valid || (vga_addr != vga_tag). It is evaluated combinationally in IDLE.
- States: IDLE, VGA_CAP, CPU_CAP, CPU_ACK.
- IDLE grant decision, evaluated every cycle:
  - VGA wins if vga_pending and !(last_vga && cpu_req). The CPU always gets the slot immediately after a VGA fetch when it is requesting.
  - Otherwise the CPU wins if cpu_req.
  - Otherwise no access (mem_en=0).
- VGA grant:
  - mem_en=1, mem_we=0, mem_addr=vga_addr. Latch vga_tag=vga_addr, tag_valid=1, last_vga=1. Next state VGA_CAP.
  - If vga_addr >= VRAM_WORDS: mem_en=0, vga_data<=0, tag updated, last_vga=1, stay in IDLE.
- VGA_CAP: vga_data<=mem_rdata; next state IDLE.
- CPU grant, common: last_vga<=0.
- CPU store: mem_en=1, mem_we=cpu_be, mem_addr=cpu_addr, mem_wdata=cpu_wdata. The write commits at the grant edge. Next state CPU_ACK.
- CPU load: mem_en=1, mem_we=0. Next state CPU_CAP; CPU_CAP latches cpu_rdata<=mem_rdata, then goes to CPU_ACK.
- CPU out-of-range (cpu_addr >= VRAM_WORDS): mem_en=0. Store is dropped; load sets cpu_rdata<=0. Still goes through CPU_ACK with the same latency.
- CPU_ACK: cpu_ack=1 for exactly this cycle; cpu_req is ignored here. Next state IDLE.
- CPU latency from grant: store ack 1 cycle after grant, load ack 2 cycles after grant. Uncontended: grant in the cycle req rises.
- VGA latency:
  - vga_data reflects a new address at most 5 cycles after the change (worst case: CPU load just granted, 3 cycles, then fetch, 2 cycles).
  - Uncontended: 2 cycles.
- Address changing again while VGA_CAP is in progress: the captured word is stored; the new address is seen as pending in the next IDLE.
- Store data is visible to a later VGA fetch of the same address: the RAM write precedes any later read.
- Reset asserted mid-operation:
  - Immediate return to IDLE; a pending cpu_ack is lost and the CPU must reissue.
  - A store granted before the reset edge has already committed.
  - tag_valid=0 forces a refetch after reset.

Optional Feature:
- Macro: VRAM_COHERENT_EN.
- Defined: on a CPU store grant with cpu_addr == vga_tag and tag_valid=1, vga_data is byte-merged with cpu_wdata per cpu_be at the same edge. The display sees the new word without waiting for an address change.
- Undefined: vga_data stays stale until vga_addr changes and a refetch occurs.

Test Plan:
- Reset, then vga_addr=5 held with RAM[5]=0xA5A5A5A5, no CPU -> mem_en in cycle 0 with mem_addr=5; vga_data=0xA5A5A5A5 two cycles later; no further mem_en while the address is held.
- CPU store addr=10, be=4'b0101, wdata=0x11223344 over RAM[10]=0 -> cpu_ack one cycle after grant; RAM[10]=0x00220044; then a load of addr 10 acks 2 cycles after grant with cpu_rdata=0x00220044.
- vga_addr change and cpu_req rise in the same cycle (last_vga=0) -> VGA granted first, CPU granted in the cycle after VGA_CAP, cpu_ack 1 cycle (store) or 2 cycles (load) after its grant.
- Back-to-back: vga_addr change while last_vga=1 and cpu_req=1 -> CPU granted first; vga_data updated within 5 cycles.
- Out of range: CPU load addr=320 -> cpu_rdata=0 with ack, mem_en never high. vga_addr=400 -> vga_data=0 with no mem_en.
- Reset pulsed during CPU_CAP -> cpu_ack never asserts, state IDLE. With VRAM_COHERENT_EN, a store to the current vga_tag updates vga_data on the grant edge; without it, vga_data is unchanged until the next address change.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - VGA, CPU and VRAM signal bundle shared by vram_arbiter and its environment
interface vram_arbiter_if #(
  parameter int AW = 9
);
  logic [AW-1:0] vga_addr;
  logic [31:0]   vga_data;

  logic          cpu_req;
  logic          cpu_we;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_ack;

  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  vga_addr, cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, mem_rdata,
    output vga_data, cpu_rdata, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vga_addr, cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_data, cpu_rdata, cpu_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between VGA scan-out fetches and CPU loads/stores
// Optional VRAM_COHERENT_EN: CPU stores to the displayed word are merged into vga_data immediately.
module vram_arbiter #(
  parameter int AW         = 9,
  parameter int VRAM_WORDS = 300
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, VGA_CAP, CPU_CAP, CPU_ACK} state_t;

  localparam logic [AW:0] WORDS = VRAM_WORDS[AW:0];

  state_t        state;
  state_t        state_next;
  logic [31:0]   vga_data_q;
  logic [31:0]   cpu_rdata_q;
  logic [AW-1:0] vga_tag;
  logic          tag_valid;
  logic          last_vga;
  logic          cpu_oor;

  logic          vga_pending;
  logic          vga_in_range;
  logic          cpu_in_range;
  logic          vga_grant;
  logic          cpu_grant;

  // Fairness: a CPU request always takes the slot right after a VGA fetch.
  always_comb begin
    vga_pending  = !tag_valid || (bus.vga_addr != vga_tag);
    vga_in_range = {1'b0, bus.vga_addr} < WORDS;
    cpu_in_range = {1'b0, bus.cpu_addr} < WORDS;
    vga_grant    = !reset && (state == IDLE) && vga_pending && !(last_vga && bus.cpu_req);
    cpu_grant    = !reset && (state == IDLE) && !vga_grant && bus.cpu_req;
  end

`ifdef VRAM_COHERENT_EN
  logic [31:0] vga_merged;
  logic        coherent_hit;

  always_comb begin
    vga_merged   = vga_data_q;
    coherent_hit = bus.cpu_we && cpu_in_range && tag_valid && (bus.cpu_addr == vga_tag);
    for (int b = 0; b < 4; b++) begin
      if (bus.cpu_be[b]) vga_merged[8*b +: 8] = bus.cpu_wdata[8*b +: 8];
    end
  end
`endif

  always_comb begin
    state_next    = state;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    case (state)
      IDLE: begin
        if (vga_grant) begin
          bus.mem_addr = bus.vga_addr;
          bus.mem_en   = vga_in_range;
          if (vga_in_range) state_next = VGA_CAP;
        end else if (cpu_grant) begin
          bus.mem_en = cpu_in_range;
          if (bus.cpu_we) begin
            if (cpu_in_range) bus.mem_we = bus.cpu_be;
            state_next = CPU_ACK;
          end else begin
            state_next = CPU_CAP;
          end
        end
      end
      VGA_CAP: state_next = IDLE;
      CPU_CAP: state_next = CPU_ACK;
      CPU_ACK: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vga_data_q  <= '0;
      cpu_rdata_q <= '0;
      vga_tag     <= '0;
      tag_valid   <= 1'b0;
      last_vga    <= 1'b0;
      cpu_oor     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (vga_grant) begin
            vga_tag   <= bus.vga_addr;
            tag_valid <= 1'b1;
            last_vga  <= 1'b1;
            if (!vga_in_range) vga_data_q <= '0;
          end else if (cpu_grant) begin
            last_vga <= 1'b0;
            cpu_oor  <= !cpu_in_range;
`ifdef VRAM_COHERENT_EN
            if (coherent_hit) vga_data_q <= vga_merged;
`endif
          end
        end
        VGA_CAP: vga_data_q  <= bus.mem_rdata;
        // Out-of-range loads still take the capture cycle so latency is uniform.
        CPU_CAP: cpu_rdata_q <= cpu_oor ? 32'h0 : bus.mem_rdata;
        default: ;
      endcase
    end
  end

  assign bus.vga_data  = vga_data_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = (state == CPU_ACK);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with a behavioural VRAM and shadow memory
module tb_vram_arbiter;
  localparam int AW    = 9;
  localparam int WORDS = 300;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vram_arbiter_if #(.AW(AW)) bus();
  vram_arbiter #(.AW(AW), .VRAM_WORDS(WORDS)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_en_cnt = 0;
  int ack_cnt = 0;
  exp_t sbq[$];

  logic [31:0]   shadow [0:(1<<AW)-1];
  logic [31:0]   ram [0:(1<<AW)-1];
  logic [31:0]   ram_q = 32'h0;
  logic          ram_init = 1'b0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = 32'h0;

  logic [31:0]   vga_exp = 32'h0;
  int            t_vga = 0;
  int            lat = 0;
  logic          first_en = 1'b0;
  logic [AW-1:0] first_addr = '0;

  assign bus.mem_rdata = ram_q;

  always @(posedge clk) cyc <= cyc + 1;

  // VRAM macro model: 1-cycle read latency, byte-enable writes
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= 32'h0;
      ram_init <= 1'b1;
    end else begin
      if (pl_en) ram[pl_addr] <= pl_data;
      if (bus.mem_en) begin
        if (bus.mem_we != 4'b0000) begin
          for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end else begin
          ram_q <= ram[bus.mem_addr];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_en) begin
      mem_en_cnt++;
      chk("mem_addr_in_range", {31'b0, ({1'b0, bus.mem_addr} < WORDS)}, 32'h1);
    end
    if (reset) begin
      chk("rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
      chk("rst_mem_we", {28'b0, bus.mem_we}, 32'h0);
    end
    if (bus.cpu_ack) begin
      ack_cnt++;
      chk("ack_has_expectation", {31'b0, (sbq.size() > 0)}, 32'h1);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        if (e.is_load) chk("cpu_rdata", bus.cpu_rdata, e.rdata);
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    shadow[a] = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_vga(input logic [AW-1:0] a);
    bus.vga_addr = a;
    vga_exp = (a < WORDS) ? shadow[a] : 32'h0;
    t_vga = cyc;
  endtask

  task automatic cpu_op(input logic we, input logic [3:0] be, input logic [AW-1:0] addr, input logic [31:0] wd);
    exp_t e;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_be = be; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    e.is_load = !we;
    e.rdata   = (addr < WORDS) ? shadow[addr] : 32'h0;
    if (we && addr < WORDS) shadow[addr] = merge(shadow[addr], wd, be);
    sbq.push_back(e);
    #1;
    first_en = bus.mem_en;
    first_addr = bus.mem_addr;
    lat = 0;
    while (lat < 20 && !bus.cpu_ack) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("cpu_ack_before_timeout", {31'b0, bus.cpu_ack}, 32'h1);
    bus.cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    int ack0;
    logic [AW-1:0] ca;
    logic [AW-1:0] va;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wd;

    for (int i = 0; i < (1 << AW); i++) shadow[i] = 32'h0;
    bus.vga_addr = 9'd5; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_be = 4'h0; bus.cpu_addr = '0; bus.cpu_wdata = 32'h0;
    tick(); tick();
    for (int i = 0; i < WORDS; i++) preload(AW'(i), $urandom);
    preload(9'd5, 32'hA5A5A5A5);  preload(9'd10, 32'h0);
    preload(9'd7, 32'h07070707);  preload(9'd20, 32'h20202020);
    preload(9'd21, 32'h21212121); preload(9'd30, 32'h30303030);
    preload(9'd31, 32'h31313131); preload(9'd40, 32'h55667788);

    chk("rst_vga_data", bus.vga_data, 32'h0);
    chk("rst_cpu_ack", {31'b0, bus.cpu_ack}, 32'h0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);

    // First fetch after reset, then no refetch while the address is held
    set_vga(9'd5);
    @(posedge clk); #1; reset = 1'b0; #1;
    chk("vga_first_mem_en", {31'b0, bus.mem_en}, 32'h1);
    chk("vga_first_mem_addr", {23'b0, bus.mem_addr}, 32'd5);
    chk("vga_first_mem_we", {28'b0, bus.mem_we}, 32'h0);
    tick(); tick();
    chk("vga_data_2cyc", bus.vga_data, 32'hA5A5A5A5);
    cnt0 = mem_en_cnt;
    repeat (6) tick();
    chk("vga_no_refetch", mem_en_cnt - cnt0, 32'd0);

    // Byte-enable store then load of the same word
    cpu_op(1'b1, 4'b0101, 9'd10, 32'h11223344);
    chk("store_grant_addr", {23'b0, first_addr}, 32'd10);
    chk("store_latency", lat, 32'd1);
    chk("ram10_after_store", ram[10], 32'h00220044);
    cpu_op(1'b0, 4'b0000, 9'd10, 32'h0);
    chk("load_latency", lat, 32'd2);

    // Simultaneous VGA change and CPU request with last_vga=0: VGA first
    set_vga(9'd20);
    cpu_op(1'b1, 4'b1111, 9'd50, 32'hDEADBEEF);
    chk("contend_vga_first_addr", {23'b0, first_addr}, 32'd20);
    chk("contend_store_latency", lat, 32'd3);
    chk("contend_vga_data", bus.vga_data, vga_exp);
    set_vga(9'd21);
    cpu_op(1'b0, 4'b0000, 9'd50, 32'h0);
    chk("contend2_vga_first_addr", {23'b0, first_addr}, 32'd21);
    chk("contend_load_latency", lat, 32'd4);

    // Back-to-back: last_vga=1 lets the CPU in first, VGA within 5 cycles
    set_vga(9'd30);
    repeat (3) tick();
    chk("b2b_prev_vga", bus.vga_data, 32'h30303030);
    set_vga(9'd31);
    cpu_op(1'b0, 4'b0000, 9'd10, 32'h0);
    chk("b2b_cpu_first_addr", {23'b0, first_addr}, 32'd10);
    chk("b2b_load_latency", lat, 32'd2);
    while (bus.vga_data != vga_exp && (cyc - t_vga) < 10) tick();
    chk("b2b_vga_data", bus.vga_data, 32'h31313131);
    chk("b2b_vga_within_5", {31'b0, ((cyc - t_vga) <= 5)}, 32'h1);

    // Out-of-range CPU load and VGA address
    cnt0 = mem_en_cnt;
    cpu_op(1'b0, 4'b0000, 9'd320, 32'h0);
    chk("oor_load_latency", lat, 32'd2);
    chk("oor_load_no_mem_en", mem_en_cnt - cnt0, 32'd0);
    cnt0 = mem_en_cnt;
    set_vga(9'd400);
    repeat (3) tick();
    chk("oor_vga_data", bus.vga_data, 32'h0);
    chk("oor_vga_no_mem_en", mem_en_cnt - cnt0, 32'd0);

    // Store granted just before reset still commits
    set_vga(9'd7);
    repeat (3) tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_be = 4'hF; bus.cpu_addr = 9'd60; bus.cpu_wdata = 32'h600DF00D;
    tick();
    reset = 1'b1; bus.cpu_req = 1'b0;
    shadow[60] = 32'h600DF00D;
    tick();
    reset = 1'b0;
    chk("store_before_reset", ram[60], 32'h600DF00D);
    repeat (3) tick();

    // Reset during CPU_CAP: ack lost, tag invalidated
    ack0 = ack_cnt;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'd10;
    tick();
    reset = 1'b1; #1;
    chk("rst_mid_cpu_ack", {31'b0, bus.cpu_ack}, 32'h0);
    chk("rst_mid_vga_data", bus.vga_data, 32'h0);
    bus.cpu_req = 1'b0;
    tick();
    reset = 1'b0; #1;
    chk("refetch_mem_en", {31'b0, bus.mem_en}, 32'h1);
    chk("refetch_mem_addr", {23'b0, bus.mem_addr}, 32'd7);
    repeat (4) tick();
    chk("rst_no_ack", ack_cnt - ack0, 32'd0);
    chk("refetch_vga_data", bus.vga_data, 32'h07070707);

    // Store to the displayed word
    set_vga(9'd40);
    repeat (3) tick();
    chk("coh_pre_vga", bus.vga_data, 32'h55667788);
    cpu_op(1'b1, 4'b1001, 9'd40, 32'hAABBCCDD);
    chk("coh_store_latency", lat, 32'd1);
`ifdef VRAM_COHERENT_EN
    chk("coh_vga_merged", bus.vga_data, 32'hAA6677DD);
`else
    chk("coh_vga_stale", bus.vga_data, 32'h55667788);
`endif
    chk("coh_ram40", ram[40], 32'hAA6677DD);
    set_vga(9'd41);
    repeat (8) tick();
    set_vga(9'd40);
    repeat (8) tick();
    chk("coh_refetch", bus.vga_data, 32'hAA6677DD);

    // Randomized traffic against the shadow memory
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        va = ($urandom_range(9, 0) == 0) ? AW'($urandom_range(511, 300)) : AW'($urandom_range(299, 0));
        set_vga(va);
      end
      if ($urandom_range(9, 0) < 7) begin
        we = 1'($urandom_range(1, 0));
        be = 4'($urandom_range(15, 0));
        wd = $urandom;
        ca = ($urandom_range(7, 0) == 0) ? AW'($urandom_range(319, 300)) : AW'($urandom_range(299, 0));
        if (we && ca == bus.vga_addr) ca = ca ^ 9'd1;
        cpu_op(we, be, ca, wd);
        if (we) chk("rand_store_latency", {31'b0, (lat >= 1 && lat <= 3)}, 32'h1);
        else    chk("rand_load_latency", {31'b0, (lat >= 2 && lat <= 4)}, 32'h1);
      end
      tick();
      while ((cyc - t_vga) < 8) tick();
      chk("rand_vga_data", bus.vga_data, vga_exp);
    end

    repeat (4) tick();
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
